// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/done bus between the memory pipeline
// stage (master) and a multi-cycle data memory (slave).
//   mem_addr/mem_wdata : address and write data, held stable for the request
//   mem_rd/mem_wr      : request strobes (at most one set)
//   mem_rdata          : read data, valid in the mem_done cycle
//   mem_done           : access completes this cycle
interface mem_stage_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_done;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_done
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_done
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. Holds the EX/MEM register, runs the
// data-memory handshake, stalls upstream while an access is outstanding,
// and writes the MEM/WB register.
//   clk, rst            : clock, asynchronous active-high reset
//   ex_*                : instruction arriving from execute
//   flush               : squash the instruction entering EX/MEM
//   mem                 : data-memory bus (master side)
//   stall               : freeze upstream stages and the EX/MEM input
//   exmem_alu_result    : EX/MEM result, forwarding source
//   wb_*                : MEM/WB register (wb_data also a forwarding source)
//   err                 : sticky fatal error (misaligned access or timeout)
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [15:0]        ex_alu_result,
    input  logic [15:0]        ex_store_data,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               ex_mem_to_reg,
    input  logic               ex_reg_write,
    input  logic [2:0]         ex_wb_reg,
    input  logic               ex_halt,
    input  logic               flush,
    mem_stage_if.master        mem,
    output logic               stall,
    output logic [15:0]        exmem_alu_result,
    output logic [15:0]        wb_data,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic               wb_halt,
    output logic [2:0]         wb_reg,
    output logic               err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ERR    = 2'd2;

    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        exm_valid_q;
    logic [15:0] exm_result_q;
    logic [15:0] exm_sdata_q;
    logic        exm_rd_q, exm_wr_q, exm_m2r_q, exm_rw_q, exm_halt_q;
    logic [2:0]  exm_reg_q;

    logic        wb_valid_q, wb_rw_q, wb_halt_q;
    logic [15:0] wb_data_q;
    logic [2:0]  wb_reg_q;

    logic        mem_op, aligned, req, done, wb_load;

    assign mem_op  = exm_valid_q & (exm_rd_q | exm_wr_q);
    assign aligned = ~exm_result_q[0];
    assign req     = mem_op & aligned & (state_q != S_ERR);
    // A done pulse outside an active request is ignored.
    assign done    = req & mem.mem_done;
    assign wb_load = exm_valid_q & (~mem_op | done) & (state_q != S_ERR);

    // Read+write together is treated as a write.
    assign mem.mem_rd    = req & ~exm_wr_q;
    assign mem.mem_wr    = req & exm_wr_q;
    assign mem.mem_addr  = req ? exm_result_q : '0;
    assign mem.mem_wdata = req ? exm_sdata_q  : '0;

    assign stall            = (mem_op & ~done) | (state_q == S_ERR);
    assign err              = (state_q == S_ERR);
    assign exmem_alu_result = exm_result_q;
    assign wb_data          = wb_data_q;
    assign wb_valid         = wb_valid_q;
    assign wb_reg_write     = wb_rw_q;
    assign wb_halt          = wb_halt_q;
    assign wb_reg           = wb_reg_q;

    // The IDLE cycle that issues a request is its first request cycle, so
    // ACCESS is entered with the counter already at 1; the timeout then
    // fires after exactly TIMEOUT request cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (mem_op) begin
                    if (!aligned) begin
                        state_d = S_ERR;
                    end else if (!done) begin
                        state_d = S_ACCESS;
                        cnt_d   = 5'd1;
                    end
                end
            end
            S_ACCESS: begin
                if (done) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exm_valid_q  <= 1'b0;
            exm_result_q <= '0;
            exm_sdata_q  <= '0;
            exm_rd_q     <= 1'b0;
            exm_wr_q     <= 1'b0;
            exm_m2r_q    <= 1'b0;
            exm_rw_q     <= 1'b0;
            exm_halt_q   <= 1'b0;
            exm_reg_q    <= '0;
        end else if (!stall) begin
            exm_valid_q  <= ex_valid & ~flush;
            exm_result_q <= ex_alu_result;
            exm_sdata_q  <= ex_store_data;
            exm_rd_q     <= ex_mem_read;
            exm_wr_q     <= ex_mem_write;
            exm_m2r_q    <= ex_mem_to_reg;
            exm_rw_q     <= ex_reg_write;
            exm_halt_q   <= ex_halt;
            exm_reg_q    <= ex_wb_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_halt_q  <= 1'b0;
            wb_data_q  <= '0;
            wb_reg_q   <= '0;
        end else if (wb_load) begin
            wb_valid_q <= 1'b1;
            wb_rw_q    <= exm_rw_q & ~exm_wr_q;
            wb_halt_q  <= exm_halt_q;
            wb_data_q  <= exm_m2r_q ? mem.mem_rdata : exm_result_q;
            wb_reg_q   <= exm_reg_q;
        end else begin
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_halt_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. Directed scenarios plus a
// randomized run against a transaction-level model of the stage.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_halt, flush;
    logic [15:0] ex_alu_result, ex_store_data;
    logic [2:0]  ex_wb_reg;
    logic        stall, wb_valid, wb_reg_write, wb_halt, err;
    logic [15:0] exmem_alu_result, wb_data;
    logic [2:0]  wb_reg;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_if mif();

    mem_stage #(.TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_alu_result    (ex_alu_result),
        .ex_store_data    (ex_store_data),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_reg_write     (ex_reg_write),
        .ex_wb_reg        (ex_wb_reg),
        .ex_halt          (ex_halt),
        .flush            (flush),
        .mem              (mif),
        .stall            (stall),
        .exmem_alu_result (exmem_alu_result),
        .wb_data          (wb_data),
        .wb_valid         (wb_valid),
        .wb_reg_write     (wb_reg_write),
        .wb_halt          (wb_halt),
        .wb_reg           (wb_reg),
        .err              (err)
    );

    task automatic drive(input logic v, input logic [15:0] res, input logic [15:0] sd,
                         input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [2:0] rg, input logic hl, input logic fl);
        ex_valid = v; ex_alu_result = res; ex_store_data = sd;
        ex_mem_read = rd; ex_mem_write = wr; ex_mem_to_reg = m2r;
        ex_reg_write = rw; ex_wb_reg = rg; ex_halt = hl; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        mif.mem_done = 1'b0;
        mif.mem_rdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // All observable outputs packed together for reset checks.
    function automatic logic [57:0] all_outs();
        return {stall, err, wb_valid, wb_reg_write, wb_halt, wb_reg, wb_data, exmem_alu_result,
                mif.mem_rd, mif.mem_wr, mif.mem_addr[15:8], mif.mem_addr[7:0] | mif.mem_wdata[7:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle();
        mif.mem_done = 1'b0;
        mif.mem_rdata = 16'h0;
        #3;
        n_tests++;
        if (all_outs() !== '0 || mif.mem_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_alu();
        int unsigned stalls = 0;
        drive(1'b1, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0);
        tick();
        idle();
        if (stall) stalls++;
        n_tests++;
        if (exmem_alu_result !== 16'h1234) begin
            n_fail++;
            $display("FAIL alu_exmem: got %h expected 1234", exmem_alu_result);
        end
        n_tests++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_wb_early: got %b expected 0", wb_valid);
        end
        tick();
        if (stall) stalls++;
        n_tests++;
        if ({wb_valid, wb_reg_write, wb_reg, wb_data} !== {1'b1, 1'b1, 3'd3, 16'h1234}) begin
            n_fail++;
            $display("FAIL alu_wb: got v=%b rw=%b r=%0d d=%h expected v=1 rw=1 r=3 d=1234",
                     wb_valid, wb_reg_write, wb_reg, wb_data);
        end
        n_tests++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL alu_stall: got %0d stall cycles expected 0", stalls);
        end
    endtask

    task automatic test_load_wait();
        int unsigned rd_cyc = 0, st_cyc = 0;
        drive(1'b1, 16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            mif.mem_done = (i == 2);
            mif.mem_rdata = (i == 2) ? 16'hBEEF : 16'hDEAD;
            #1;
            if (mif.mem_rd && mif.mem_addr == 16'h0040) rd_cyc++;
            if (stall) st_cyc++;
            tick();
        end
        mif.mem_done = 1'b0;
        n_tests++;
        if (rd_cyc != 3) begin
            n_fail++;
            $display("FAIL load_rd_cycles: got %0d expected 3", rd_cyc);
        end
        n_tests++;
        if (st_cyc != 2) begin
            n_fail++;
            $display("FAIL load_stall_cycles: got %0d expected 2", st_cyc);
        end
        n_tests++;
        if ({wb_valid, wb_reg_write, wb_reg, wb_data, mif.mem_rd} !== {1'b1, 1'b1, 3'd5, 16'hBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL load_wb: got v=%b rw=%b r=%0d d=%h rd=%b expected v=1 rw=1 r=5 d=beef rd=0",
                     wb_valid, wb_reg_write, wb_reg, wb_data, mif.mem_rd);
        end
    endtask

    task automatic test_back_to_back();
        mif.mem_done = 1'b1;
        drive(1'b1, 16'h0010, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0012, 16'h5555, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
        #1;
        n_tests++;
        if ({mif.mem_wr, mif.mem_rd, mif.mem_addr, mif.mem_wdata, stall} !== {1'b1, 1'b0, 16'h0010, 16'hAAAA, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_first: got wr=%b rd=%b a=%h d=%h st=%b expected wr=1 rd=0 a=0010 d=aaaa st=0",
                     mif.mem_wr, mif.mem_rd, mif.mem_addr, mif.mem_wdata, stall);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if ({mif.mem_wr, mif.mem_addr, mif.mem_wdata, stall} !== {1'b1, 16'h0012, 16'h5555, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_second: got wr=%b a=%h d=%h st=%b expected wr=1 a=0012 d=5555 st=0",
                     mif.mem_wr, mif.mem_addr, mif.mem_wdata, stall);
        end
        n_tests++;
        if ({wb_valid, wb_reg_write} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_wb1: got v=%b rw=%b expected v=1 rw=0", wb_valid, wb_reg_write);
        end
        tick();
        n_tests++;
        if ({wb_valid, wb_reg_write, mif.mem_wr} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_wb2: got v=%b rw=%b wr=%b expected v=1 rw=0 wr=0", wb_valid, wb_reg_write, mif.mem_wr);
        end
        mif.mem_done = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        drive(1'b1, 16'h0011, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
        tick();
        idle();
        n_tests++;
        if ({mif.mem_rd, mif.mem_wr, err, stall} !== 4'b0001) begin
            n_fail++;
            $display("FAIL misalign_issue: got rd=%b wr=%b err=%b st=%b expected 0 0 0 1",
                     mif.mem_rd, mif.mem_wr, err, stall);
        end
        tick();
        n_tests++;
        if ({err, stall, mif.mem_rd} !== 3'b110) begin
            n_fail++;
            $display("FAIL misalign_err: got err=%b st=%b rd=%b expected 1 1 0", err, stall, mif.mem_rd);
        end
        drive(1'b1, 16'h0700, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
        repeat (4) tick();
        n_tests++;
        if ({err, stall, wb_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL misalign_sticky: got err=%b st=%b wbv=%b expected 1 1 0", err, stall, wb_valid);
        end
        idle();
        rst = 1'b1;
        #1;
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL misalign_rst: got %h expected 0", all_outs());
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int unsigned rd_cyc = 0;
        mif.mem_done = 1'b0;
        drive(1'b1, 16'h0020, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 40 && !err; i++) begin
            if (mif.mem_rd) rd_cyc++;
            tick();
        end
        n_tests++;
        if (rd_cyc != 16) begin
            n_fail++;
            $display("FAIL timeout_rd_cycles: got %0d expected 16", rd_cyc);
        end
        n_tests++;
        if ({err, mif.mem_rd, stall} !== 3'b101) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%b rd=%b st=%b expected 1 0 1", err, mif.mem_rd, stall);
        end
        do_reset();
        // Reset in the middle of an access drops the strobe at once.
        drive(1'b1, 16'h0030, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if ({mif.mem_rd, stall, mif.mem_addr} !== {1'b0, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_access: got rd=%b st=%b a=%h expected 0 0 0000", mif.mem_rd, stall, mif.mem_addr);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 16'h0040, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
        tick();
        // Flushed ALU op presented while the load is stalled.
        drive(1'b1, 16'h0777, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1);
        mif.mem_done = 1'b0;
        tick();
        n_tests++;
        if ({exmem_alu_result, mif.mem_rd, stall} !== {16'h0040, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_stalled: got res=%h rd=%b st=%b expected 0040 1 1", exmem_alu_result, mif.mem_rd, stall);
        end
        mif.mem_done = 1'b1;
        mif.mem_rdata = 16'h4321;
        tick();
        mif.mem_done = 1'b0;
        idle();
        n_tests++;
        if ({wb_valid, wb_reg, wb_data} !== {1'b1, 3'd6, 16'h4321}) begin
            n_fail++;
            $display("FAIL flush_load_wb: got v=%b r=%0d d=%h expected 1 6 4321", wb_valid, wb_reg, wb_data);
        end
        tick();
        n_tests++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_bubble_a: got %b expected 0", wb_valid);
        end
        drive(1'b1, 16'h0888, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        n_tests++;
        if ({wb_valid, wb_reg_write} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_bubble_b: got v=%b rw=%b expected 0 0", wb_valid, wb_reg_write);
        end
    endtask

    // Model: the instruction occupying the stage either completes this cycle
    // (non-memory, or memory reporting done) or keeps upstream frozen. The
    // memory answers every request after a random 1..4 request cycles.
    task automatic test_random(input int unsigned ncyc);
        logic        s_v, s_rd, s_wr, s_m2r, s_rw, s_hl, acc, memop, done, p_wb, p_rw, p_hl;
        logic [15:0] s_res, s_sd, p_data, rdat, e_addr, e_wdata;
        logic [2:0]  s_rg, p_rg;
        int unsigned lat, cnt, kind;
        do_reset();
        s_v = 0; s_rd = 0; s_wr = 0; s_m2r = 0; s_rw = 0; s_hl = 0; s_res = 0; s_sd = 0; s_rg = 0;
        p_wb = 0; p_rw = 0; p_hl = 0; p_data = 16'h0; p_rg = 0;
        acc = 1; lat = 0; cnt = 0;
        for (int unsigned c = 0; c < ncyc; c++) begin
            if (p_wb) begin
                n_tests++;
                if ({wb_valid, wb_reg_write, wb_halt, wb_reg, wb_data} !== {1'b1, p_rw, p_hl, p_rg, p_data}) begin
                    n_fail++;
                    $display("FAIL rand_wb c=%0d: got v=%b rw=%b h=%b r=%0d d=%h expected 1 %b %b %0d %h",
                             c, wb_valid, wb_reg_write, wb_halt, wb_reg, wb_data, p_rw, p_hl, p_rg, p_data);
                end
            end else begin
                n_tests++;
                if ({wb_valid, wb_reg_write, wb_halt, wb_data} !== {3'b000, p_data}) begin
                    n_fail++;
                    $display("FAIL rand_bubble c=%0d: got v=%b rw=%b h=%b d=%h expected 0 0 0 %h",
                             c, wb_valid, wb_reg_write, wb_halt, wb_data, p_data);
                end
            end
            if (acc) begin
                kind = $urandom_range(0, 3);
                ex_valid      = ($urandom_range(0, 3) != 0);
                ex_alu_result = 16'($urandom);
                if (kind != 0) ex_alu_result[0] = 1'b0;
                ex_store_data = 16'($urandom);
                ex_mem_read   = (kind == 1) || (kind == 3);
                ex_mem_write  = (kind >= 2);
                ex_mem_to_reg = 1'($urandom);
                ex_reg_write  = 1'($urandom);
                ex_wb_reg     = 3'($urandom);
                ex_halt       = ($urandom_range(0, 15) == 0);
                flush         = ($urandom_range(0, 5) == 0);
            end
            memop = s_v & (s_rd | s_wr);
            done = 1'b0;
            if (memop) begin
                if (cnt == 0) lat = $urandom_range(1, 4);
                cnt++;
                done = (cnt == lat);
            end
            mif.mem_done = memop ? done : ($urandom_range(0, 2) == 0);
            rdat = 16'($urandom);
            mif.mem_rdata = rdat;
            #1;
            e_addr  = memop ? s_res : 16'h0;
            e_wdata = memop ? s_sd  : 16'h0;
            n_tests++;
            if ({mif.mem_rd, mif.mem_wr, mif.mem_addr, mif.mem_wdata, stall, err, exmem_alu_result} !==
                {memop & ~s_wr, memop & s_wr, e_addr, e_wdata, memop & ~done, 1'b0, s_res}) begin
                n_fail++;
                $display("FAIL rand_bus c=%0d: got rd=%b wr=%b a=%h d=%h st=%b err=%b res=%h expected %b %b %h %h %b 0 %h",
                         c, mif.mem_rd, mif.mem_wr, mif.mem_addr, mif.mem_wdata, stall, err, exmem_alu_result,
                         memop & ~s_wr, memop & s_wr, e_addr, e_wdata, memop & ~done, s_res);
            end
            p_wb = s_v & (~memop | done);
            if (p_wb) begin
                p_data = s_m2r ? rdat : s_res;
                p_rw = s_rw & ~s_wr;
                p_hl = s_hl;
                p_rg = s_rg;
            end
            acc = ~(memop & ~done);
            if (done) cnt = 0;
            if (acc) begin
                s_v = ex_valid & ~flush; s_res = ex_alu_result; s_sd = ex_store_data;
                s_rd = ex_mem_read; s_wr = ex_mem_write; s_m2r = ex_mem_to_reg;
                s_rw = ex_reg_write; s_rg = ex_wb_reg; s_hl = ex_halt;
            end
            tick();
        end
        idle();
        mif.mem_done = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_flush();
        test_random(3000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
